// File: rtl/led_stretch.sv
// Per-channel LED pulse stretcher: each event becomes a visible blink of
// HOLD_CYC lit cycles followed by at least GAP_CYC dark cycles, with one queued blink.
module led_stretch #(
  parameter int unsigned N        = 10,
  parameter int unsigned HOLD_CYC = 5,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic         clk,
  input  logic         iRST_n,
  input  logic [N-1:0] iEVT,
  input  logic         iCLR,
  output logic [N-1:0] oLED,
  output logic [N-1:0] oPEND,
  output logic         oANY
);

  localparam int unsigned MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [N-1:0][1:0]    state_q, state_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]         pend_q, pend_d;
  logic [N-1:0]         led_q, led_d;
  logic                 any_q, any_d;

  // Next-state per channel; outputs decoded from next state so they are registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    led_d   = '0;
    any_d   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (iCLR) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        pend_d[i]  = 1'b0;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (iEVT[i]) begin
              state_d[i] = S_ON;
              cnt_d[i]   = HOLD_LD;
            end
          end
          S_ON: begin
            if (iEVT[i]) begin
              pend_d[i] = 1'b1;
            end
            if (cnt_q[i] == '0) begin
              state_d[i] = S_GAP;
              cnt_d[i]   = GAP_LD;
            end else begin
              cnt_d[i] = cnt_q[i] - CW'(1);
            end
          end
          S_GAP: begin
            if (cnt_q[i] == '0) begin
              // An event on the expiry edge counts as queued: go straight back to ON.
              if (pend_q[i] || iEVT[i]) begin
                state_d[i] = S_ON;
                cnt_d[i]   = HOLD_LD;
                pend_d[i]  = 1'b0;
              end else begin
                state_d[i] = S_IDLE;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - CW'(1);
              if (iEVT[i]) begin
                pend_d[i] = 1'b1;
              end
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
            pend_d[i]  = 1'b0;
          end
        endcase
      end
      led_d[i] = (state_d[i] == S_ON);
      any_d    = any_d | (state_d[i] != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      led_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      any_q   <= any_d;
    end
  end

  assign oLED  = led_q;
  assign oPEND = pend_q;
  assign oANY  = any_q;

endmodule

// File: tb/tb_led_stretch.sv
// Self-checking bench for led_stretch: directed scenarios plus randomized
// traffic compared against a blink-schedule reference model.
module tb_led_stretch;

  localparam int N        = 10;
  localparam int HOLD_CYC = 5;
  localparam int GAP_CYC  = 2;

  logic         clk;
  logic         iRST_n;
  logic [N-1:0] iEVT;
  logic         iCLR;
  logic [N-1:0] oLED;
  logic [N-1:0] oPEND;
  logic         oANY;

  int n_chk;
  int n_pass;

  // Reference model: each channel remembers the edge its current blink started.
  int m_now;
  int m_start [N];
  bit m_act   [N];
  bit m_pend  [N];

  logic [N-1:0] e_led;
  logic [N-1:0] e_pend;
  logic         e_any;

  led_stretch #(
    .N       (N),
    .HOLD_CYC(HOLD_CYC),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk   (clk),
    .iRST_n(iRST_n),
    .iEVT  (iEVT),
    .iCLR  (iCLR),
    .oLED  (oLED),
    .oPEND (oPEND),
    .oANY  (oANY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_now = 0;
    for (int i = 0; i < N; i++) begin
      m_act[i]   = 1'b0;
      m_pend[i]  = 1'b0;
      m_start[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] evt, input logic clr);
    m_now++;
    for (int i = 0; i < N; i++) begin
      if (clr) begin
        m_act[i]  = 1'b0;
        m_pend[i] = 1'b0;
      end else if (m_act[i] && (m_now - m_start[i]) < HOLD_CYC + GAP_CYC) begin
        if (evt[i]) m_pend[i] = 1'b1;
      end else if (m_pend[i] || evt[i]) begin
        m_act[i]   = 1'b1;
        m_start[i] = m_now;
        m_pend[i]  = 1'b0;
      end else begin
        m_act[i] = 1'b0;
      end
    end
    e_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      e_led[i]  = m_act[i] && ((m_now - m_start[i]) < HOLD_CYC);
      e_pend[i] = m_pend[i];
      e_any     = e_any | (m_act[i] && ((m_now - m_start[i]) < HOLD_CYC + GAP_CYC));
    end
  endtask

  // Drive one edge, advance the model, land 1 time unit after the edge.
  task automatic step(input logic [N-1:0] evt, input logic clr);
    iEVT = evt;
    iCLR = clr;
    @(posedge clk);
    model_edge(evt, clr);
    #1;
    iEVT = '0;
    iCLR = 1'b0;
  endtask

  task automatic test_reset();
    iRST_n = 1'b0;
    iEVT   = '1;
    iCLR   = 1'b0;
    #23;
    n_chk++;
    if ({oLED, oPEND, oANY} !== '0)
      $display("FAIL reset_outputs: got led=%h pend=%h any=%b want all 0", oLED, oPEND, oANY);
    else n_pass++;
    @(negedge clk);
    iEVT   = '0;
    iRST_n = 1'b1;
    model_clear();
    step('0, 1'b0);
    n_chk++;
    if ({oLED, oPEND, oANY} !== '0)
      $display("FAIL reset_no_memory: got led=%h pend=%h any=%b want all 0", oLED, oPEND, oANY);
    else n_pass++;
  endtask

  task automatic test_single_pulse();
    logic [N-1:0] evt;
    for (int k = 0; k <= 20; k++) begin
      evt = '0;
      evt[0] = (k == 10);
      step(evt, 1'b0);
      n_chk++;
      if (oLED[0] !== (k >= 10 && k <= 14) || oANY !== (k >= 10 && k <= 16) || oPEND[0] !== 1'b0)
        $display("FAIL single_pulse k=%0d: got led0=%b any=%b pend0=%b", k, oLED[0], oANY, oPEND[0]);
      else n_pass++;
      n_chk++;
      if ({oLED, oPEND, oANY} !== {e_led, e_pend, e_any})
        $display("FAIL single_pulse_model k=%0d: got %h/%h/%b want %h/%h/%b",
                 k, oLED, oPEND, oANY, e_led, e_pend, e_any);
      else n_pass++;
    end
  endtask

  task automatic test_queued();
    logic [N-1:0] evt;
    logic         lit;
    for (int k = 0; k <= 25; k++) begin
      evt = '0;
      evt[3] = (k == 10) || (k == 12);
      evt[5] = (k == 10) || (k == 16);
      step(evt, 1'b0);
      lit = (k >= 10 && k <= 14) || (k >= 17 && k <= 21);
      n_chk++;
      if (oLED[3] !== lit || oLED[5] !== lit || oPEND[3] !== (k >= 12 && k <= 16) ||
          oPEND[5] !== (k == 16) || oANY !== (k >= 10 && k <= 23))
        $display("FAIL queued k=%0d: got led3=%b led5=%b pend3=%b pend5=%b any=%b",
                 k, oLED[3], oLED[5], oPEND[3], oPEND[5], oANY);
      else n_pass++;
      n_chk++;
      if ({oLED, oPEND, oANY} !== {e_led, e_pend, e_any})
        $display("FAIL queued_model k=%0d: got %h/%h/%b want %h/%h/%b",
                 k, oLED, oPEND, oANY, e_led, e_pend, e_any);
      else n_pass++;
    end
  endtask

  task automatic test_held();
    logic [N-1:0] evt;
    for (int k = 0; k < 40; k++) begin
      evt = '0;
      evt[9] = (k < 20);
      step(evt, 1'b0);
      if (k < 20) begin
        n_chk++;
        if (oLED[9] !== ((k % (HOLD_CYC + GAP_CYC)) < HOLD_CYC))
          $display("FAIL held k=%0d: got led9=%b want %b", k, oLED[9],
                   ((k % (HOLD_CYC + GAP_CYC)) < HOLD_CYC));
        else n_pass++;
      end
      n_chk++;
      if ({oLED, oPEND, oANY} !== {e_led, e_pend, e_any})
        $display("FAIL held_model k=%0d: got %h/%h/%b want %h/%h/%b",
                 k, oLED, oPEND, oANY, e_led, e_pend, e_any);
      else n_pass++;
    end
  endtask

  task automatic test_clear();
    for (int k = 0; k <= 9; k++) begin
      step((k == 4 || k == 5) ? {N{1'b1}} : '0, (k == 4 || k == 7));
      if (k == 4 || k == 7) begin
        n_chk++;
        if (oLED !== '0 || oANY !== 1'b0 || oPEND !== '0)
          $display("FAIL clear k=%0d: got led=%h pend=%h any=%b want 0", k, oLED, oPEND, oANY);
        else n_pass++;
      end
      if (k == 5) begin
        n_chk++;
        if (oLED !== {N{1'b1}} || oANY !== 1'b1)
          $display("FAIL clear_then_evt: got led=%h any=%b want 3ff/1", oLED, oANY);
        else n_pass++;
      end
      n_chk++;
      if ({oLED, oPEND, oANY} !== {e_led, e_pend, e_any})
        $display("FAIL clear_model k=%0d: got %h/%h/%b want %h/%h/%b",
                 k, oLED, oPEND, oANY, e_led, e_pend, e_any);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] evt;
    for (int k = 0; k <= 12; k++) begin
      evt = '0;
      evt[0] = (k == 10) || (k == 12);
      step(evt, 1'b0);
    end
    n_chk++;
    if (oLED[0] !== 1'b1 || oPEND[0] !== 1'b1 || oANY !== 1'b1)
      $display("FAIL areset_pre: got led0=%b pend0=%b any=%b want 1/1/1", oLED[0], oPEND[0], oANY);
    else n_pass++;
    #2;
    iRST_n = 1'b0;
    #1;
    n_chk++;
    if ({oLED, oPEND, oANY} !== '0)
      $display("FAIL areset_async: got led=%h pend=%h any=%b want 0", oLED, oPEND, oANY);
    else n_pass++;
    iEVT = '1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_chk++;
    if ({oLED, oPEND, oANY} !== '0)
      $display("FAIL areset_hold: got led=%h pend=%h any=%b want 0", oLED, oPEND, oANY);
    else n_pass++;
    @(negedge clk);
    iEVT   = '0;
    iRST_n = 1'b1;
    model_clear();
    for (int k = 0; k < 10; k++) begin
      step('0, 1'b0);
      n_chk++;
      if ({oLED, oPEND, oANY} !== '0)
        $display("FAIL areset_quiet k=%0d: got led=%h pend=%h any=%b want 0", k, oLED, oPEND, oANY);
      else n_pass++;
    end
    evt = '0;
    evt[0] = 1'b1;
    step(evt, 1'b0);
    n_chk++;
    if (oLED !== evt || oPEND !== '0 || oANY !== 1'b1)
      $display("FAIL areset_fresh: got led=%h pend=%h any=%b want 001/000/1", oLED, oPEND, oANY);
    else n_pass++;
    for (int k = 0; k < 10; k++) step('0, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] evt;
    logic         clr;
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < N; i++) evt[i] = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 49) == 0);
      step(evt, clr);
      n_chk++;
      if ({oLED, oPEND, oANY} !== {e_led, e_pend, e_any})
        $display("FAIL random k=%0d: got %h/%h/%b want %h/%h/%b",
                 k, oLED, oPEND, oANY, e_led, e_pend, e_any);
      else n_pass++;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    e_led  = '0;
    e_pend = '0;
    e_any  = 1'b0;
    model_clear();
    test_reset();
    test_single_pulse();
    test_queued();
    test_held();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
